// File: rtl/pulse_seq_if.sv
// Handshake/config bundle between a controller and pulse_seq_ctrl; with PSEQ_BURST_EN the
// write data grows by TW bits so register 7 can carry BURST above the two step fields.
interface pulse_seq_if #(
  parameter int W  = 16,
  parameter int TW = 16
);
  localparam int DW = (W > TW) ? W : TW;
`ifdef PSEQ_BURST_EN
  localparam int CW = DW + TW;
`else
  localparam int CW = DW;
`endif

  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          start;
  logic          stop;
  logic [W-1:0]  out;
  logic [2:0]    phase;
  logic          busy;
  logic          period_done;
  logic          cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop,
    input  out, phase, busy, period_done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop,
    output out, phase, busy, period_done, cfg_err
  );
endinterface

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer DELAY->RISE->HIGH->FALL->LOW with clamped ramps; PSEQ_BURST_EN limits period count.
// All outputs registered, start acts at the sampling edge; no backpressure, busy writes dropped.
module pulse_seq_ctrl #(
  parameter int W  = 16,
  parameter int TW = 16
) (
  input logic        clk,
  input logic        rst,
  pulse_seq_if.slave bus
);
  localparam int DW = (W > TW) ? W : TW;
  localparam int HW = DW / 2;
`ifdef PSEQ_BURST_EN
  localparam int CW = DW + TW;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    RISE  = 3'd2,
    HIGH  = 3'd3,
    FALL  = 3'd4,
    LOW   = 3'd5
  } phase_t;

  logic signed [W-1:0] iv, pv;
  logic [TW-1:0]       td, tr, th, tf, per;
  logic [W-1:0]        rstep, fstep;
  logic [DW-1:0]       lo_ext, hi_ext;
`ifdef PSEQ_BURST_EN
  logic [TW-1:0]       burst, bcnt, bcnt_nxt;
`endif

  phase_t              ph, ph_nxt, tgt, after;
  logic [TW-1:0]       cnt, cnt_nxt;
  logic signed [W-1:0] out_r, out_nxt;
  logic                pdone_r, pdone_nxt, err_r, enter;

  logic [TW+1:0]       active_sum;
  logic [TW-1:0]       low_len;
  logic                periodic;

  assign active_sum = {2'b0, tr} + {2'b0, th} + {2'b0, tf};
  assign low_len    = ({2'b0, per} > active_sum) ? TW'({2'b0, per} - active_sum) : '0;
  assign periodic   = (per != '0);

  function automatic logic [TW-1:0] dur(input phase_t p);
    case (p)
      DELAY:   dur = td;
      RISE:    dur = tr;
      HIGH:    dur = th;
      FALL:    dur = tf;
      LOW:     dur = low_len;
      default: dur = '0;
    endcase
  endfunction

  // First phase at or after 'from' with a non-zero duration; periodic mode wraps to RISE.
  function automatic phase_t pick(input logic [2:0] from);
    pick = IDLE;
    if (from <= DELAY && td != '0)      pick = DELAY;
    else if (from <= RISE && tr != '0)  pick = RISE;
    else if (from <= HIGH && th != '0)  pick = HIGH;
    else if (from <= FALL && tf != '0)  pick = FALL;
    else if (periodic) begin
      if (from <= LOW && low_len != '0) pick = LOW;
      else if (tr != '0)                pick = RISE;
      else if (th != '0)                pick = HIGH;
      else if (tf != '0)                pick = FALL;
      else                              pick = LOW;
    end
  endfunction

  function automatic logic signed [W-1:0] ramp(input logic signed [W-1:0] from,
                                                input logic [W-1:0]        step,
                                                input logic signed [W-1:0] target);
    logic signed [W+1:0] f, t, d, s;
    f    = (W+2)'(from);
    t    = (W+2)'(target);
    d    = (W+2)'(step);
    ramp = target;
    if (t >= f) begin
      s = f + d;
      if (s < t) ramp = s[W-1:0];
    end else begin
      s = f - d;
      if (s > t) ramp = s[W-1:0];
    end
  endfunction

  always_comb begin
    ph_nxt    = ph;
    cnt_nxt   = cnt;
    out_nxt   = out_r;
    pdone_nxt = 1'b0;
    enter     = 1'b0;
    tgt       = IDLE;
    after     = IDLE;
`ifdef PSEQ_BURST_EN
    bcnt_nxt  = bcnt;
`endif
    if (bus.stop) begin
      ph_nxt  = IDLE;
      cnt_nxt = '0;
`ifdef PSEQ_BURST_EN
      bcnt_nxt = '0;
`endif
    end else if (ph == IDLE) begin
      if (bus.start) begin
        tgt       = pick(3'd0);
        enter     = 1'b1;
        pdone_nxt = (tgt == IDLE);
      end
    end else if (cnt != '0) begin
      cnt_nxt = cnt - TW'(1);
    end else begin
      tgt   = pick(3'(ph) + 3'd1);
      enter = 1'b1;
`ifdef PSEQ_BURST_EN
      // Going back to an earlier (or the same) phase closes a period.
      if (tgt != IDLE && tgt <= ph) begin
        if (burst != '0 && (bcnt + TW'(1)) == burst) begin
          tgt      = IDLE;
          bcnt_nxt = '0;
        end else begin
          bcnt_nxt = bcnt + TW'(1);
        end
      end
`endif
    end

    if (enter) begin
      ph_nxt  = tgt;
      cnt_nxt = (tgt == IDLE) ? '0 : dur(tgt) - TW'(1);
    end

    // period_done is high during the final cycle of a period, so look one phase ahead.
    if (ph_nxt != IDLE && cnt_nxt == '0) begin
      after     = pick(3'(ph_nxt) + 3'd1);
      pdone_nxt = (after == IDLE) || (after <= ph_nxt);
    end

    case (ph_nxt)
      RISE:    out_nxt = (cnt_nxt == '0) ? pv : ramp(enter ? iv : out_r, rstep, pv);
      HIGH:    out_nxt = pv;
      FALL:    out_nxt = (cnt_nxt == '0) ? iv : ramp(enter ? pv : out_r, fstep, iv);
      default: out_nxt = iv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph      <= IDLE;
      cnt     <= '0;
      out_r   <= '0;
      pdone_r <= 1'b0;
      err_r   <= 1'b0;
`ifdef PSEQ_BURST_EN
      bcnt    <= '0;
`endif
    end else begin
      ph      <= ph_nxt;
      cnt     <= cnt_nxt;
      out_r   <= out_nxt;
      pdone_r <= pdone_nxt;
      err_r   <= bus.cfg_we && (ph != IDLE);
`ifdef PSEQ_BURST_EN
      bcnt    <= bcnt_nxt;
`endif
    end
  end

  assign lo_ext = DW'(bus.cfg_wdata[HW-1:0]);
  assign hi_ext = DW'(bus.cfg_wdata[DW-1:HW]);

  always_ff @(posedge clk) begin
    if (rst) begin
      iv    <= '0;
      pv    <= '0;
      td    <= '0;
      tr    <= '0;
      th    <= '0;
      tf    <= '0;
      per   <= '0;
      rstep <= '0;
      fstep <= '0;
`ifdef PSEQ_BURST_EN
      burst <= '0;
`endif
    end else if (bus.cfg_we && ph == IDLE) begin
      case (bus.cfg_addr)
        3'd0:    iv  <= bus.cfg_wdata[W-1:0];
        3'd1:    pv  <= bus.cfg_wdata[W-1:0];
        3'd2:    td  <= bus.cfg_wdata[TW-1:0];
        3'd3:    tr  <= bus.cfg_wdata[TW-1:0];
        3'd4:    th  <= bus.cfg_wdata[TW-1:0];
        3'd5:    tf  <= bus.cfg_wdata[TW-1:0];
        3'd6:    per <= bus.cfg_wdata[TW-1:0];
        default: begin
          rstep <= lo_ext[W-1:0];
          fstep <= hi_ext[W-1:0];
`ifdef PSEQ_BURST_EN
          burst <= bus.cfg_wdata[CW-1:DW];
`endif
        end
      endcase
    end
  end

  assign bus.out         = out_r;
  assign bus.phase       = ph;
  assign bus.busy        = (ph != IDLE);
  assign bus.period_done = pdone_r;
  assign bus.cfg_err     = err_r;
endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Directed bench for pulse_seq_ctrl: vector tables for whole waveforms plus short hand sequences.
module tb_pulse_seq_ctrl;
  localparam int DW = 16;
`ifdef PSEQ_BURST_EN
  localparam int CW = DW + 16;
`else
  localparam int CW = DW;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_seq_if #(.W(16), .TW(16)) bus ();
  pulse_seq_ctrl #(.W(16), .TW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] out;
    logic [2:0]  phase;
    logic        pd;
  } vec_t;

  vec_t vq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = CW'(d);
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic v(input logic s, input logic p, input logic [15:0] o,
                   input logic [2:0] ph, input logic pd);
    vec_t e;
    e.start = s; e.stop = p; e.out = o; e.phase = ph; e.pd = pd;
    vq.push_back(e);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      bus.start = vq[i].start;
      bus.stop  = vq[i].stop;
      tick();
      chk($sformatf("%s[%0d].out", tag, i),   32'(bus.out),         32'(vq[i].out));
      chk($sformatf("%s[%0d].phase", tag, i), 32'(bus.phase),       32'(vq[i].phase));
      chk($sformatf("%s[%0d].pd", tag, i),    32'(bus.period_done), 32'(vq[i].pd));
      chk($sformatf("%s[%0d].busy", tag, i),  32'(bus.busy),        32'(vq[i].phase != 3'd0));
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    vq.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    tick(); tick();
    chk("rst.out", 32'(bus.out), 0);
    chk("rst.phase", 32'(bus.phase), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.pd", 32'(bus.period_done), 0);
    chk("rst.err", 32'(bus.cfg_err), 0);
    rst = 1'b0;

    // Load config, start, then reset mid-sequence: config must clear too.
    wr(3'd0, 5); wr(3'd2, 3);
    tick();
    chk("idle.iv", 32'(bus.out), 5);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("td.phase", 32'(bus.phase), 1);
    chk("td.out", 32'(bus.out), 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2.out", 32'(bus.out), 0);
    chk("rst2.phase", 32'(bus.phase), 0);
    chk("rst2.busy", 32'(bus.busy), 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("zero.pd", 32'(bus.period_done), 1);
    chk("zero.phase", 32'(bus.phase), 0);
    tick();
    chk("zero.pd_end", 32'(bus.period_done), 0);

    // Single-shot ramp.
    wr(3'd0, 0); wr(3'd1, 100); wr(3'd2, 2); wr(3'd3, 4);
    wr(3'd4, 3); wr(3'd5, 2); wr(3'd6, 0); wr(3'd7, 32'h0000_3C1E);
    v(1,0,16'd0,3'd1,0);   v(0,0,16'd0,3'd1,0);
    v(0,0,16'd30,3'd2,0);  v(0,0,16'd60,3'd2,0);
    v(0,0,16'd90,3'd2,0);  v(0,0,16'd100,3'd2,0);
    v(0,0,16'd100,3'd3,0); v(0,0,16'd100,3'd3,0); v(0,0,16'd100,3'd3,0);
    v(0,0,16'd40,3'd4,0);  v(0,0,16'd0,3'd4,1);
    v(0,0,16'd0,3'd0,0);
    run_vecs("single");

    // Periodic with LOW, TD only once; a start while busy is ignored.
    wr(3'd1, 50); wr(3'd2, 1); wr(3'd3, 1); wr(3'd4, 2); wr(3'd5, 1); wr(3'd6, 8);
    v(1,0,16'd0,3'd1,0);
    for (int p = 0; p < 2; p++) begin
      v(0,0,16'd50,3'd2,0); v(0,0,16'd50,3'd3,0); v(0,0,16'd50,3'd3,0);
      v(0,0,16'd0,3'd4,0);
      v(0,0,16'd0,3'd5,0);  v(1,0,16'd0,3'd5,0);  v(0,0,16'd0,3'd5,0);
      v(0,0,16'd0,3'd5,1);
    end
    v(0,0,16'd50,3'd2,0);
    v(0,1,16'd0,3'd0,0);
    run_vecs("periodic");

    // Short period, TR=0, descending pulse with a clamped FALL step; then stop cases.
    wr(3'd0, 10); wr(3'd1, 32'h0000_FFEC); wr(3'd2, 0); wr(3'd3, 0);
    wr(3'd4, 2); wr(3'd5, 3); wr(3'd6, 3); wr(3'd7, 32'h0000_1400);
    v(1,0,16'hFFEC,3'd3,0); v(0,0,16'hFFEC,3'd3,0);
    v(0,0,16'd0,3'd4,0);    v(0,0,16'd10,3'd4,0);  v(0,0,16'd10,3'd4,1);
    v(0,0,16'hFFEC,3'd3,0);
    v(0,1,16'd10,3'd0,0);
    v(1,1,16'd10,3'd0,0);
    run_vecs("short");

    // Write while busy is dropped and flagged.
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("busy.phase", 32'(bus.phase), 3);
    wr(3'd1, 77);
    chk("busy.err", 32'(bus.cfg_err), 1);
    chk("busy.out", 32'(bus.out), 32'h0000_FFEC);
    tick();
    chk("busy.err_end", 32'(bus.cfg_err), 0);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("busy.pv_kept", 32'(bus.out), 32'h0000_FFEC);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("idle.err", 32'(bus.cfg_err), 0);

    // A write is visible to a start on the very next edge.
    wr(3'd1, 77);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("vis.out", 32'(bus.out), 77);
    chk("vis.phase", 32'(bus.phase), 3);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;

`ifdef PSEQ_BURST_EN
    begin
      int pd_cnt;
      pd_cnt = 0;
      wr(3'd0, 0); wr(3'd1, 9); wr(3'd3, 1); wr(3'd4, 1); wr(3'd5, 1); wr(3'd6, 3);
      wr(3'd7, 32'h0003_0000);
      bus.start = 1'b1;
      for (int i = 0; i < 12; i++) begin
        tick();
        bus.start = 1'b0;
        if (bus.period_done) pd_cnt++;
      end
      chk("burst.count", 32'(pd_cnt), 3);
      chk("burst.busy", 32'(bus.busy), 0);
      chk("burst.out", 32'(bus.out), 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
